// File: rtl/lifo_stream_reader.sv
// lifo_stream_reader: pops a LIFO and re-emits the words as a valid/ready stream, newest first.
// Latency: rdreq in cycle t -> m_valid_o in cycle t+2; sustains 1 word/cycle.
// Backpressure: 2-entry skid buffer covers the read latency; `LIFO_RD_LAST_EN adds m_last_o.
module lifo_stream_reader #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic              drain_en_i,
    output logic              lifo_rdreq_o,
    input  logic [DWIDTH-1:0] lifo_q_i,
    input  logic              lifo_empty_i,
    input  logic [AWIDTH:0]   lifo_usedw_i,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              busy_o
`ifdef LIFO_RD_LAST_EN
    ,
    output logic              m_last_o
`endif
);

    logic              inflight;
    logic [1:0]        buf_cnt;
    logic [1:0]        buf_cnt_nxt;
    logic [DWIDTH-1:0] head_dat;
    logic [DWIDTH-1:0] tail_dat;
    logic              pop;
    logic [2:0]        occ_after;
    logic              wr_tail;
    logic              busy_q;

    assign m_valid_o   = (buf_cnt != 2'd0);
    assign m_data_o    = head_dat;
    assign busy_o      = busy_q;
    assign pop         = m_valid_o & m_ready_i;
    // Occupancy left after this cycle's transfer; the ready path here is what allows back-to-back pops.
    assign occ_after   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign lifo_rdreq_o = srst_n_i & drain_en_i & ~lifo_empty_i & (occ_after < 3'd2);
    assign buf_cnt_nxt = buf_cnt + {1'b0, inflight} - {1'b0, pop};
    // A returning word lands behind whatever survives this cycle's pop.
    assign wr_tail     = (buf_cnt != {1'b0, pop});

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            busy_q   <= 1'b0;
            head_dat <= '0;
            tail_dat <= '0;
        end else begin
            inflight <= lifo_rdreq_o;
            buf_cnt  <= buf_cnt_nxt;
            busy_q   <= lifo_rdreq_o | (buf_cnt_nxt != 2'd0);
            if (pop) begin
                head_dat <= tail_dat;
            end
            if (inflight) begin
                if (wr_tail) begin
                    tail_dat <= lifo_q_i;
                end else begin
                    head_dat <= lifo_q_i;
                end
            end
        end
    end

`ifdef LIFO_RD_LAST_EN
    logic inflight_last;
    logic head_last;
    logic tail_last;

    assign m_last_o = head_last;

    // Tag follows its word through the same head/tail moves as the data.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            inflight_last <= 1'b0;
            head_last     <= 1'b0;
            tail_last     <= 1'b0;
        end else begin
            inflight_last <= (lifo_usedw_i == (AWIDTH+1)'(1));
            if (pop) begin
                head_last <= tail_last;
            end
            if (inflight) begin
                if (wr_tail) begin
                    tail_last <= inflight_last;
                end else begin
                    head_last <= inflight_last;
                end
            end
        end
    end
`else
    logic unused_usedw;
    assign unused_usedw = ^lifo_usedw_i;
`endif

endmodule
